// File: rtl/jtag_mem_reader.sv
// JTAG memory readback engine: fetches a byte range through the shared memory
// arbiter, offers each byte to the JTAG shifter and keeps a mod-256 checksum.
//
// state   | meaning
// IDLE    | waiting for start_i
// REQ     | requesting the memory port for addr_q
// CAPTURE | read data arrives, byte is registered
// HOLD    | byte offered to JTAG side until accepted
// FINISH  | transfer complete, done pulse issued on exit

package jtag_mem_reader_pkg;
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_width_t;
endpackage

module jtag_mem_reader
  import jtag_mem_reader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 11
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  length_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [7:0]        checksum_o,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output mem_width_t        mem_width_o,
  input  logic [31:0]       mem_data_i,
  output logic [7:0]        byte_o,
  output logic              byte_valid_o,
  input  logic              byte_ready_i
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [7:0]         byte_q, byte_d;
  logic               valid_q, valid_d;
  logic [7:0]         checksum_q, checksum_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Only the low byte lane carries data for BYTE-width reads.
  logic unused_data;
  assign unused_data = ^mem_data_i[31:8];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      byte_q      <= '0;
      valid_q     <= 1'b0;
      checksum_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      byte_q      <= byte_d;
      valid_q     <= valid_d;
      checksum_q  <= checksum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    byte_d      = byte_q;
    valid_d     = valid_q;
    checksum_d  = checksum_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = base_addr_i;
          remaining_d = length_i;
          checksum_d  = '0;
          busy_d      = 1'b1;
          state_d     = (length_i == '0) ? FINISH : REQ;
        end
      end
      REQ: begin
        if (mem_gnt_i) state_d = CAPTURE;
      end
      CAPTURE: begin
        byte_d      = mem_data_i[7:0];
        valid_d     = 1'b1;
        addr_d      = addr_q + ADDR_W'(1);
        remaining_d = remaining_q - LEN_W'(1);
        state_d     = HOLD;
      end
      HOLD: begin
        if (valid_q && byte_ready_i) begin
          checksum_d = checksum_q + byte_q;
          valid_d    = 1'b0;
          state_d    = (remaining_q != '0) ? REQ : FINISH;
        end
      end
      FINISH: begin
        // done rises and busy falls on the same edge
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign checksum_o   = checksum_q;
  assign mem_req_o    = (state_q == REQ);
  assign mem_addr_o   = addr_q;
  assign mem_width_o  = BYTE;
  assign byte_o       = byte_q;
  assign byte_valid_o = valid_q;

endmodule

// File: tb/tb_jtag_mem_reader.sv
// Self-checking bench for jtag_mem_reader: transaction-level model of the
// byte stream, addresses, timing and checksum plus directed literal checks.
module tb_jtag_mem_reader;
  import jtag_mem_reader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int LEN_W  = 11;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [LEN_W-1:0]  length_i = '0;
  logic              busy_o, done_o;
  logic [7:0]        checksum_o;
  logic              mem_req_o;
  logic              mem_gnt_i = 1'b1;
  logic [ADDR_W-1:0] mem_addr_o;
  mem_width_t        mem_width_o;
  logic [31:0]       mem_data_i = 32'hDEADBEEF;
  logic [7:0]        byte_o;
  logic              byte_valid_o;
  logic              byte_ready_i = 1'b1;

  jtag_mem_reader #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .length_i(length_i),
    .busy_o(busy_o), .done_o(done_o), .checksum_o(checksum_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o),
    .mem_width_o(mem_width_o), .mem_data_i(mem_data_i),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Memory model and stall controls
  logic [7:0]        mem [0:1023];
  logic              rd_pend = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  int                gnt_stall = 0;
  int                rdy_stall = 0;

  always @(negedge clk_i) begin
    rd_pend = rst_i && mem_req_o && mem_gnt_i;
    rd_addr = mem_addr_o;
  end

  always @(posedge clk_i) begin
    #1;
    mem_data_i = rd_pend ? {24'h5A5A5A, mem[rd_addr]} : 32'hDEADBEEF;
    if (mem_req_o && gnt_stall > 0) begin
      mem_gnt_i = 1'b0;
      gnt_stall--;
    end else begin
      mem_gnt_i = 1'b1;
    end
    if (byte_valid_o && rdy_stall > 0) begin
      byte_ready_i = 1'b0;
      rdy_stall--;
    end else begin
      byte_ready_i = 1'b1;
    end
  end

  // Transaction model: expected bytes/addresses and event timing
  int                cyc = 0;
  bit                active = 1'b0;
  int                start_cyc = 0;
  int                next_evt = 0;
  int                done_due = -1;
  logic [7:0]        msum = '0;
  logic [7:0]        exp_b[$];
  logic [ADDR_W-1:0] exp_a[$];
  logic [7:0]        got_b[$];
  logic [ADDR_W-1:0] got_a[$];
  logic [7:0]        last_ck = '0;
  int                last_gap = 0;
  int                done_cnt = 0;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      active = 1'b0;
      exp_b.delete();
      exp_a.delete();
      msum = '0;
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_req", mem_req_o, 0);
      chk("rst_valid", byte_valid_o, 0);
      chk("rst_byte", byte_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_cksum", checksum_o, 0);
    end else begin
      chk("width", mem_width_o, BYTE);
      if (active && cyc > start_cyc) begin
        chk("busy", busy_o, (cyc == done_due) ? 0 : 1);
        chk("cksum_run", checksum_o, msum);
        if (mem_req_o) begin
          chk("req_expected", mem_req_o, exp_a.size() != 0);
          if (exp_a.size() != 0) begin
            chk("req_addr", mem_addr_o, exp_a[0]);
            if (mem_gnt_i) begin
              got_a.push_back(mem_addr_o);
              void'(exp_a.pop_front());
            end else begin
              next_evt++;
            end
          end
        end
        if (byte_valid_o) begin
          chk("valid_expected", byte_valid_o, exp_b.size() != 0);
          if (exp_b.size() != 0) begin
            chk("byte", byte_o, exp_b[0]);
            if (byte_ready_i) begin
              chk("accept_cycle", cyc, next_evt);
              got_b.push_back(byte_o);
              msum = msum + exp_b.pop_front();
              next_evt = cyc + 3;
              if (exp_b.size() == 0) done_due = cyc + 2;
            end else begin
              next_evt++;
            end
          end
        end
        chk("done", done_o, cyc == done_due);
        if (done_o) done_cnt++;
        if (cyc == done_due) begin
          last_ck  = checksum_o;
          last_gap = cyc - start_cyc;
          chk("done_cksum", checksum_o, msum);
          chk("done_all_bytes", exp_b.size(), 0);
          active = 1'b0;
        end
      end else if (!active) begin
        chk("idle_done", done_o, 0);
        chk("idle_req", mem_req_o, 0);
        chk("idle_valid", byte_valid_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_cksum", checksum_o, msum);
        if (done_o) done_cnt++;
      end
      if (!active && start_i) begin
        active    = 1'b1;
        start_cyc = cyc;
        msum      = '0;
        exp_b.delete();
        exp_a.delete();
        got_b.delete();
        got_a.delete();
        for (int i = 0; i < int'(length_i); i++) begin
          exp_a.push_back(ADDR_W'(int'(base_addr_i) + i));
          exp_b.push_back(mem[ADDR_W'(int'(base_addr_i) + i)]);
        end
        if (length_i == '0) begin
          done_due = cyc + 2;
          next_evt = -1;
        end else begin
          done_due = -1;
          next_evt = cyc + 3;
        end
      end
    end
  end

  // Stimulus helpers
  task automatic go(input logic [ADDR_W-1:0] base, input logic [LEN_W-1:0] len);
    @(posedge clk_i);
    #1;
    start_i = 1'b1;
    base_addr_i = base;
    length_i = len;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    base_addr_i = 10'h2AA;
    length_i = 11'd7;
  endtask

  task automatic wait_done(input string tag, input int maxcyc);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < maxcyc; i++) begin
      @(posedge clk_i);
      if (done_cnt != d0) break;
    end
    chk({tag, "_done_seen"}, done_cnt != d0, 1);
    repeat (4) @(posedge clk_i);
    chk({tag, "_done_once"}, done_cnt - d0, 1);
  endtask

  logic [7:0]        eb[4];
  logic [ADDR_W-1:0] ea[4];

  task automatic check_run(input string tag, input int n, input logic [7:0] ck, input int gap);
    chk({tag, "_nbytes"}, got_b.size(), n);
    chk({tag, "_naddr"}, got_a.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_b.size()) chk({tag, "_lit_byte"}, got_b[i], eb[i]);
      if (i < got_a.size()) chk({tag, "_lit_addr"}, got_a[i], ea[i]);
    end
    chk({tag, "_lit_cksum"}, last_ck, ck);
    chk({tag, "_lit_gap"}, last_gap, gap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int  d0;
    bit  found;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[10'h010] = 8'h11; mem[10'h011] = 8'h22;
    mem[10'h012] = 8'h33; mem[10'h013] = 8'h44;
    mem[10'h3FE] = 8'h01; mem[10'h3FF] = 8'h02; mem[10'h000] = 8'h03;
    mem[10'h020] = 8'h5C;

    repeat (3) @(posedge clk_i);
    #3 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // Basic 4-byte stream
    go(10'h010, 11'd4);
    wait_done("t1", 40);
    eb = '{8'h11, 8'h22, 8'h33, 8'h44};
    ea = '{10'h010, 10'h011, 10'h012, 10'h013};
    check_run("t1", 4, 8'hAA, 14);

    // Address wrap
    go(10'h3FE, 11'd3);
    wait_done("t2", 40);
    eb = '{8'h01, 8'h02, 8'h03, 8'h00};
    ea = '{10'h3FE, 10'h3FF, 10'h000, 10'h000};
    check_run("t2", 3, 8'h06, 11);

    // Zero length
    go(10'h123, 11'd0);
    wait_done("t3", 20);
    check_run("t3", 0, 8'h00, 2);

    // Grant stall then ready stall
    gnt_stall = 5;
    rdy_stall = 4;
    go(10'h020, 11'd1);
    wait_done("t4", 40);
    eb = '{8'h5C, 8'h00, 8'h00, 8'h00};
    ea = '{10'h020, 10'h000, 10'h000, 10'h000};
    check_run("t4", 1, 8'h5C, 14);

    // Start ignored while busy
    go(10'h010, 11'd4);
    repeat (3) @(posedge clk_i);
    #1;
    start_i = 1'b1;
    base_addr_i = 10'h3FE;
    length_i = 11'd3;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_done("t5", 40);
    eb = '{8'h11, 8'h22, 8'h33, 8'h44};
    ea = '{10'h010, 10'h011, 10'h012, 10'h013};
    check_run("t5", 4, 8'hAA, 14);

    // Reset during HOLD aborts with no done
    go(10'h010, 11'd4);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_i);
      #1;
      if (byte_valid_o) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_hold_reached", found, 1);
    d0 = done_cnt;
    #1 rst_i = 1'b0;
    #1;
    chk("t6_async_valid", byte_valid_o, 0);
    chk("t6_async_busy", busy_o, 0);
    chk("t6_async_byte", byte_o, 0);
    chk("t6_async_addr", mem_addr_o, 0);
    chk("t6_async_cksum", checksum_o, 0);
    repeat (3) @(posedge clk_i);
    #3 rst_i = 1'b1;
    repeat (5) @(posedge clk_i);
    chk("t6_no_done", done_cnt - d0, 0);
    go(10'h010, 11'd1);
    wait_done("t6", 30);
    eb = '{8'h11, 8'h00, 8'h00, 8'h00};
    ea = '{10'h010, 10'h000, 10'h000, 10'h000};
    check_run("t6", 1, 8'h11, 5);

    repeat (3) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
